// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM burst arbiter and its helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sdram_arb_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_WR  = 2'd1,
    GNT_RD  = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Client indices, used for the round-robin last-grant memory
  localparam logic CLIENT_WR = 1'b0;
  localparam logic CLIENT_RD = 1'b1;

  // Cycles a burst may hold the controller before it is forcibly released
  localparam int DEFAULT_TIMEOUT_CYCLES = 4095;

endpackage

// File: rtl/burst_watchdog.sv
// Saturating cycle counter that flags when a granted burst has run for LIMIT cycles.
// Latency: expire is combinational in the LIMIT-th enabled cycle after a clear.
// Backpressure: none; clr dominates en, counter holds at LIMIT once saturated.
module burst_watchdog #(
  parameter int LIMIT = 4095
) (
  input  logic mem_clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] FULL = CW'(LIMIT);

  logic [CW-1:0] count_q;

  // Count enabled cycles since the last clear, saturating at LIMIT
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != FULL)) begin
      count_q <= count_q + CW'(1);
    end
  end

  // count_q holds the number of enabled cycles already completed, so the
  // current cycle is the LIMIT-th one when count_q has reached LIMIT-1
  assign expire = en && !clr && (count_q >= LAST);

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller user port between a write and a read burst client.
// Latency: controller req rises one cycle after the client request is sampled in IDLE; one RELEASE cycle between bursts.
// Backpressure: client requests are level and wait in IDLE; a hung burst is dropped by the watchdog after TIMEOUT_CYCLES.
module sdram_burst_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int MEM_DATA_BITS  = 32,
  parameter int ADDR_BITS      = 23,
  parameter int BURST_BITS     = 10,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  // write client
  input  logic                     c_wr_burst_req,
  input  logic [BURST_BITS-1:0]    c_wr_burst_len,
  input  logic [ADDR_BITS-1:0]     c_wr_burst_addr,
  input  logic [MEM_DATA_BITS-1:0] c_wr_burst_data,
  output logic                     c_wr_burst_data_req,
  output logic                     c_wr_burst_finish,
  // read client
  input  logic                     c_rd_burst_req,
  input  logic [BURST_BITS-1:0]    c_rd_burst_len,
  input  logic [ADDR_BITS-1:0]     c_rd_burst_addr,
  output logic                     c_rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] c_rd_burst_data,
  output logic                     c_rd_burst_finish,
  // controller write port
  output logic                     wr_burst_req,
  output logic [BURST_BITS-1:0]    wr_burst_len,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_data_req,
  input  logic                     wr_burst_finish,
  // controller read port
  output logic                     rd_burst_req,
  output logic [BURST_BITS-1:0]    rd_burst_len,
  output logic [ADDR_BITS-1:0]     rd_burst_addr,
  input  logic                     rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
  input  logic                     rd_burst_finish,
  // status
  output logic                     grant_wr,
  output logic                     grant_rd,
  output logic                     arb_timeout,
  output logic                     arb_err
);

  arb_state_e state_q, state_d;

  logic                  last_grant_q;
  logic                  zero_len_q;
  logic                  arb_err_q;
  logic                  wr_req_q, rd_req_q;
  logic [BURST_BITS-1:0] wr_len_q, rd_len_q;
  logic [ADDR_BITS-1:0]  wr_addr_q, rd_addr_q;

  logic pick_wr, pick_rd;
  logic in_gnt_wr, in_gnt_rd;
  logic wr_done, rd_done;
  logic wd_en, wd_clr, wd_expire;
  logic timeout_evt;

  burst_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .mem_clk (mem_clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expire  (wd_expire)
  );

  // Arbitration and completion terms shared by the FSM and datapath
  always_comb begin
    pick_wr     = c_wr_burst_req && (!c_rd_burst_req || (last_grant_q == CLIENT_RD));
    pick_rd     = c_rd_burst_req && !pick_wr;
    in_gnt_wr   = (state_q == GNT_WR);
    in_gnt_rd   = (state_q == GNT_RD);
    // a zero-length burst completes in its first granted cycle
    wr_done     = in_gnt_wr && (wr_burst_finish || zero_len_q);
    rd_done     = in_gnt_rd && (rd_burst_finish || zero_len_q);
    wd_en       = in_gnt_wr || in_gnt_rd;
    wd_clr      = !wd_en;
    // a real completion in the expiry cycle takes precedence over the watchdog
    timeout_evt = wd_expire && !wr_done && !rd_done;
  end

  // FSM state register
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_wr) begin
          state_d = GNT_WR;
        end else if (pick_rd) begin
          state_d = GNT_RD;
        end
      end
      GNT_WR:  if (wr_done || wd_expire) state_d = RELEASE;
      GNT_RD:  if (rd_done || wd_expire) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: grants, gated finish pulses and watchdog status
  always_comb begin
    grant_wr          = in_gnt_wr;
    grant_rd          = in_gnt_rd;
    c_wr_burst_finish = in_gnt_wr && (wr_burst_finish || zero_len_q || wd_expire);
    c_rd_burst_finish = in_gnt_rd && (rd_burst_finish || zero_len_q || wd_expire);
    arb_timeout       = timeout_evt;
    arb_err           = arb_err_q;
  end

  // Latch the winner's burst descriptor at grant and retire controller requests
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= CLIENT_RD;
      zero_len_q   <= 1'b0;
      arb_err_q    <= 1'b0;
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      wr_len_q     <= '0;
      rd_len_q     <= '0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
    end else begin
      arb_err_q <= arb_err_q || timeout_evt;
      case (state_q)
        IDLE: begin
          if (pick_wr) begin
            wr_len_q     <= c_wr_burst_len;
            wr_addr_q    <= c_wr_burst_addr;
            wr_req_q     <= (c_wr_burst_len != '0);
            zero_len_q   <= (c_wr_burst_len == '0);
            last_grant_q <= CLIENT_WR;
          end else if (pick_rd) begin
            rd_len_q     <= c_rd_burst_len;
            rd_addr_q    <= c_rd_burst_addr;
            rd_req_q     <= (c_rd_burst_len != '0);
            zero_len_q   <= (c_rd_burst_len == '0);
            last_grant_q <= CLIENT_RD;
          end
        end
        GNT_WR: begin
          zero_len_q <= 1'b0;
          if (wr_burst_data_req || wr_done || wd_expire) wr_req_q <= 1'b0;
        end
        GNT_RD: begin
          zero_len_q <= 1'b0;
          if (rd_burst_data_valid || rd_done || wd_expire) rd_req_q <= 1'b0;
        end
        default: begin
          zero_len_q <= 1'b0;
        end
      endcase
    end
  end

  // The controller sees the request dropped in the expiry cycle itself
  assign wr_burst_req  = wr_req_q && !wd_expire;
  assign rd_burst_req  = rd_req_q && !wd_expire;
  assign wr_burst_len  = wr_len_q;
  assign wr_burst_addr = wr_addr_q;
  assign rd_burst_len  = rd_len_q;
  assign rd_burst_addr = rd_addr_q;

  // Data path routing; strobes only reach the granted client
  assign wr_burst_data         = c_wr_burst_data;
  assign c_wr_burst_data_req   = wr_burst_data_req && grant_wr;
  assign c_rd_burst_data_valid = rd_burst_data_valid && grant_rd;
  assign c_rd_burst_data       = rd_burst_data;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed bench for sdram_burst_arbiter: one instance with a long watchdog for
// normal traffic, a second with a 16-cycle watchdog for the hung-burst case.
module tb_sdram_burst_arbiter;

  logic        mem_clk;
  logic        rst_n;
  logic        rst_to_n;

  logic        c_wr_burst_req;
  logic [9:0]  c_wr_burst_len;
  logic [22:0] c_wr_burst_addr;
  logic [31:0] c_wr_burst_data;
  logic        c_rd_burst_req;
  logic [9:0]  c_rd_burst_len;
  logic [22:0] c_rd_burst_addr;
  logic        wr_burst_data_req;
  logic        wr_burst_finish;
  logic        rd_burst_data_valid;
  logic [31:0] rd_burst_data;
  logic        rd_burst_finish;

  // main instance outputs
  logic        c_wr_burst_data_req, c_wr_burst_finish;
  logic        c_rd_burst_data_valid, c_rd_burst_finish;
  logic [31:0] c_rd_burst_data;
  logic        wr_burst_req, rd_burst_req;
  logic [9:0]  wr_burst_len, rd_burst_len;
  logic [22:0] wr_burst_addr, rd_burst_addr;
  logic [31:0] wr_burst_data;
  logic        grant_wr, grant_rd, arb_timeout, arb_err;

  // short-watchdog instance outputs
  logic        to_c_wr_burst_data_req, to_c_wr_burst_finish;
  logic        to_c_rd_burst_data_valid, to_c_rd_burst_finish;
  logic [31:0] to_c_rd_burst_data;
  logic        to_wr_burst_req, to_rd_burst_req;
  logic [9:0]  to_wr_burst_len, to_rd_burst_len;
  logic [22:0] to_wr_burst_addr, to_rd_burst_addr;
  logic [31:0] to_wr_burst_data;
  logic        to_grant_wr, to_grant_rd, to_arb_timeout, to_arb_err;

  int errors = 0;
  int checks = 0;
  int to_pulses;
  int to_fins;

  sdram_burst_arbiter #(
    .MEM_DATA_BITS(32), .ADDR_BITS(23), .BURST_BITS(10), .TIMEOUT_CYCLES(300)
  ) dut (
    .mem_clk(mem_clk), .rst_n(rst_n),
    .c_wr_burst_req(c_wr_burst_req), .c_wr_burst_len(c_wr_burst_len),
    .c_wr_burst_addr(c_wr_burst_addr), .c_wr_burst_data(c_wr_burst_data),
    .c_wr_burst_data_req(c_wr_burst_data_req), .c_wr_burst_finish(c_wr_burst_finish),
    .c_rd_burst_req(c_rd_burst_req), .c_rd_burst_len(c_rd_burst_len),
    .c_rd_burst_addr(c_rd_burst_addr), .c_rd_burst_data_valid(c_rd_burst_data_valid),
    .c_rd_burst_data(c_rd_burst_data), .c_rd_burst_finish(c_rd_burst_finish),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len),
    .wr_burst_addr(wr_burst_addr), .wr_burst_data(wr_burst_data),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish),
    .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len),
    .rd_burst_addr(rd_burst_addr), .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_data(rd_burst_data), .rd_burst_finish(rd_burst_finish),
    .grant_wr(grant_wr), .grant_rd(grant_rd),
    .arb_timeout(arb_timeout), .arb_err(arb_err)
  );

  sdram_burst_arbiter #(
    .MEM_DATA_BITS(32), .ADDR_BITS(23), .BURST_BITS(10), .TIMEOUT_CYCLES(16)
  ) dut_to (
    .mem_clk(mem_clk), .rst_n(rst_to_n),
    .c_wr_burst_req(c_wr_burst_req), .c_wr_burst_len(c_wr_burst_len),
    .c_wr_burst_addr(c_wr_burst_addr), .c_wr_burst_data(c_wr_burst_data),
    .c_wr_burst_data_req(to_c_wr_burst_data_req), .c_wr_burst_finish(to_c_wr_burst_finish),
    .c_rd_burst_req(c_rd_burst_req), .c_rd_burst_len(c_rd_burst_len),
    .c_rd_burst_addr(c_rd_burst_addr), .c_rd_burst_data_valid(to_c_rd_burst_data_valid),
    .c_rd_burst_data(to_c_rd_burst_data), .c_rd_burst_finish(to_c_rd_burst_finish),
    .wr_burst_req(to_wr_burst_req), .wr_burst_len(to_wr_burst_len),
    .wr_burst_addr(to_wr_burst_addr), .wr_burst_data(to_wr_burst_data),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish),
    .rd_burst_req(to_rd_burst_req), .rd_burst_len(to_rd_burst_len),
    .rd_burst_addr(to_rd_burst_addr), .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_data(rd_burst_data), .rd_burst_finish(rd_burst_finish),
    .grant_wr(to_grant_wr), .grant_rd(to_grant_rd),
    .arb_timeout(to_arb_timeout), .arb_err(to_arb_err)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // step to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  // Called one unit after the grant edge. Plays the controller for n words on
  // the granted port, then finishes, and returns inside the RELEASE cycle.
  task automatic do_burst(input bit exp_wr, input int n, input int exp_addr, input bit inject);
    int strobes;
    strobes = 0;
    #1;
    check("grant_owner", 32'(exp_wr ? grant_wr : grant_rd), 1);
    check("grant_other", 32'(exp_wr ? grant_rd : grant_wr), 0);
    check("ctrl_req_at_grant", 32'(exp_wr ? wr_burst_req : rd_burst_req), 1);
    check("ctrl_len", 32'(exp_wr ? wr_burst_len : rd_burst_len), n);
    check("ctrl_addr", 32'(exp_wr ? wr_burst_addr : rd_burst_addr), exp_addr);
    for (int i = 0; i < n; i++) begin
      if (exp_wr) begin
        wr_burst_data_req = 1'b1;
        c_wr_burst_data   = 32'hA000_0000 + 32'(i);
      end else begin
        rd_burst_data_valid = 1'b1;
        rd_burst_data       = 32'hB000_0000 + 32'(i);
      end
      if (inject && i == 10) begin
        rd_burst_data_valid = 1'b1;
        rd_burst_finish     = 1'b1;
      end
      #1;
      if (exp_wr ? c_wr_burst_data_req : c_rd_burst_data_valid) strobes++;
      if (i == 0)
        check("data_route", exp_wr ? wr_burst_data : c_rd_burst_data,
              exp_wr ? 32'hA000_0000 : 32'hB000_0000);
      if (i == 1)
        check("ctrl_req_dropped", 32'(exp_wr ? wr_burst_req : rd_burst_req), 0);
      if (inject && i == 10) begin
        check("foreign_rd_valid", 32'(c_rd_burst_data_valid), 0);
        check("foreign_rd_finish", 32'(c_rd_burst_finish), 0);
      end
      tick();
      if (inject && i == 10) begin
        rd_burst_data_valid = 1'b0;
        rd_burst_finish     = 1'b0;
      end
    end
    wr_burst_data_req   = 1'b0;
    rd_burst_data_valid = 1'b0;
    if (exp_wr) wr_burst_finish = 1'b1;
    else        rd_burst_finish = 1'b1;
    #1;
    check("client_finish", 32'(exp_wr ? c_wr_burst_finish : c_rd_burst_finish), 1);
    tick();
    wr_burst_finish = 1'b0;
    rd_burst_finish = 1'b0;
    #1;
    check("release_grants", 32'({grant_wr, grant_rd}), 0);
    check("release_finish", 32'({c_wr_burst_finish, c_rd_burst_finish}), 0);
    check("strobe_count", strobes, n);
  endtask

  initial begin
    rst_n = 1'b0; rst_to_n = 1'b0;
    c_wr_burst_req = 1'b0; c_wr_burst_len = '0; c_wr_burst_addr = '0; c_wr_burst_data = '0;
    c_rd_burst_req = 1'b0; c_rd_burst_len = '0; c_rd_burst_addr = '0;
    wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
    rd_burst_data_valid = 1'b0; rd_burst_data = '0; rd_burst_finish = 1'b0;

    // reset values
    #2;
    check("rst_grants", 32'({grant_wr, grant_rd}), 0);
    check("rst_ctrl_req", 32'({wr_burst_req, rd_burst_req}), 0);
    check("rst_wr_len", 32'(wr_burst_len), 0);
    check("rst_wr_addr", 32'(wr_burst_addr), 0);
    check("rst_status", 32'({arb_timeout, arb_err}), 0);

    // tie straight after reset, then continuous requests alternate W,R,W,R
    tick();
    rst_n = 1'b1;
    c_wr_burst_req = 1'b1; c_wr_burst_len = 10'd4; c_wr_burst_addr = 23'h10;
    c_rd_burst_req = 1'b1; c_rd_burst_len = 10'd3; c_rd_burst_addr = 23'h20;
    tick();
    do_burst(1'b1, 4, 'h10, 1'b0);
    tick(); tick();
    do_burst(1'b0, 3, 'h20, 1'b0);
    tick(); tick();
    do_burst(1'b1, 4, 'h10, 1'b0);
    tick(); tick();
    do_burst(1'b0, 3, 'h20, 1'b0);
    c_wr_burst_req = 1'b0; c_rd_burst_req = 1'b0;

    // 128-word write with foreign read strobes injected mid-burst
    c_wr_burst_req = 1'b1; c_wr_burst_len = 10'd128; c_wr_burst_addr = 23'h000100;
    tick();
    #1;
    check("idle_no_wr_req", 32'(wr_burst_req), 0);
    tick();
    c_wr_burst_req = 1'b0;
    do_burst(1'b1, 128, 'h100, 1'b1);

    // zero-length read, followed by a normal write
    c_rd_burst_req = 1'b1; c_rd_burst_len = 10'd0; c_rd_burst_addr = 23'h55;
    tick(); tick();
    c_rd_burst_req = 1'b0;
    #1;
    check("zl_grant_rd", 32'(grant_rd), 1);
    check("zl_no_rd_req", 32'(rd_burst_req), 0);
    check("zl_finish", 32'(c_rd_burst_finish), 1);
    c_wr_burst_req = 1'b1; c_wr_burst_len = 10'd2; c_wr_burst_addr = 23'h80;
    tick();
    #1;
    check("zl_release_grant", 32'(grant_rd), 0);
    check("zl_release_finish", 32'(c_rd_burst_finish), 0);
    check("zl_release_req", 32'(rd_burst_req), 0);
    tick(); tick();
    c_wr_burst_req = 1'b0;
    do_burst(1'b1, 2, 'h80, 1'b0);

    // hung read: short-watchdog instance times out, main instance keeps waiting
    rst_to_n = 1'b1;
    tick();
    c_rd_burst_req = 1'b1; c_rd_burst_len = 10'd8; c_rd_burst_addr = 23'h40;
    tick();
    c_rd_burst_req = 1'b0;
    to_pulses = 0;
    to_fins = 0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (to_arb_timeout) to_pulses++;
      if (to_c_rd_burst_finish) to_fins++;
      if (k == 1) begin
        check("to_grant_rd", 32'(to_grant_rd), 1);
        check("to_err_before", 32'(to_arb_err), 0);
      end
      if (k == 15) begin
        check("to_req_before", 32'(to_rd_burst_req), 1);
        check("to_no_early_pulse", 32'(to_arb_timeout), 0);
      end
      if (k == 16) begin
        check("to_req_dropped", 32'(to_rd_burst_req), 0);
        check("to_pulse", 32'(to_arb_timeout), 1);
        check("to_client_finish", 32'(to_c_rd_burst_finish), 1);
      end
      if (k == 17) begin
        check("to_release_grant", 32'(to_grant_rd), 0);
        check("to_err_set", 32'(to_arb_err), 1);
      end
      tick();
    end
    rd_burst_finish = 1'b1;
    #1;
    check("late_finish_ignored", 32'(to_c_rd_burst_finish), 0);
    check("late_no_pulse", 32'(to_arb_timeout), 0);
    check("main_rd_finish", 32'(c_rd_burst_finish), 1);
    tick();
    rd_burst_finish = 1'b0;
    check("to_err_sticky", 32'(to_arb_err), 1);
    check("to_pulse_count", to_pulses, 1);
    check("to_finish_count", to_fins, 1);
    check("main_no_err", 32'(arb_err), 0);

    // reset at word 40 of a 128-word write
    c_wr_burst_req = 1'b1; c_wr_burst_len = 10'd128; c_wr_burst_addr = 23'h200;
    tick(); tick();
    c_wr_burst_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      wr_burst_data_req = 1'b1;
      tick();
    end
    rst_n = 1'b0; rst_to_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant_wr), 0);
    check("mid_rst_req", 32'(wr_burst_req), 0);
    check("mid_rst_len", 32'(wr_burst_len), 0);
    check("mid_rst_addr", 32'(wr_burst_addr), 0);
    check("mid_rst_strobe", 32'(c_wr_burst_data_req), 0);
    check("mid_rst_to_err", 32'(to_arb_err), 0);
    wr_burst_data_req = 1'b0;
    c_wr_burst_req = 1'b1; c_wr_burst_len = 10'd5; c_wr_burst_addr = 23'h300;
    c_rd_burst_req = 1'b1; c_rd_burst_len = 10'd6; c_rd_burst_addr = 23'h310;
    tick();
    rst_n = 1'b1; rst_to_n = 1'b1;
    tick();
    do_burst(1'b1, 5, 'h300, 1'b0);
    c_wr_burst_req = 1'b0; c_rd_burst_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_burst_arbiter.md
Name: sdram_burst_arbiter

Overview:
- Shares the single SDRAM controller user interface between two burst clients: the frame writer (write port) and the frame reader/UART sender (read port).
- Grants whole bursts with round-robin priority when both clients request.
- Latches each burst's address and length at grant, routes data and handshakes to the granted client only, and recovers from a hung burst with a watchdog.
- Sits between the frame write/read sequencers and the SDRAM controller, in the mem_clk domain.

Parameters:
- MEM_DATA_BITS, 32, controller user-interface data width
- ADDR_BITS, 23, controller user-interface address width
- BURST_BITS, 10, burst length field width, in words
- TIMEOUT_CYCLES, 4095, maximum cycles in a granted state before forced release

Ports:
- mem_clk  in  1  controller user-interface clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- c_wr_burst_req  in  1  write client requests a burst (level)
- c_wr_burst_len  in  BURST_BITS  write client burst length
- c_wr_burst_addr  in  ADDR_BITS  write client base address
- c_wr_burst_data  in  MEM_DATA_BITS  write client data
- c_wr_burst_data_req  out  1  write data strobe to the client
- c_wr_burst_finish  out  1  write burst done pulse to the client
- c_rd_burst_req  in  1  read client requests a burst (level)
- c_rd_burst_len  in  BURST_BITS  read client burst length
- c_rd_burst_addr  in  ADDR_BITS  read client base address
- c_rd_burst_data_valid  out  1  read data valid to the client
- c_rd_burst_data  out  MEM_DATA_BITS  read data to the client
- c_rd_burst_finish  out  1  read burst done pulse to the client
- wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data  out  1/BURST_BITS/ADDR_BITS/MEM_DATA_BITS  to the controller
- wr_burst_data_req, wr_burst_finish  in  1/1  from the controller
- rd_burst_req, rd_burst_len, rd_burst_addr  out  1/BURST_BITS/ADDR_BITS  to the controller
- rd_burst_data_valid, rd_burst_data, rd_burst_finish  in  1/MEM_DATA_BITS/1  from the controller
- grant_wr, grant_rd  out  1  current owner of the controller (one-hot or zero)
- arb_timeout  out  1  one-cycle pulse on watchdog release
- arb_err  out  1  sticky error flag; set by arb_timeout, cleared only by rst_n

Behaviour:
- Reset: state=IDLE. All controller req outputs 0, len/addr 0, grants 0, arb_timeout 0, arb_err 0, last_grant=RD (so write wins the first tie), watchdog 0.
- States: IDLE, GNT_WR, GNT_RD, RELEASE.
- IDLE, request sampled in cycle N:
  - Only one client requesting: that client is chosen.
  - Both requesting: the client opposite last_grant is chosen.
  - At the N edge: latch the chosen client's len/addr into the controller-side registers, set grant, set last_grant, enter GNT_x.
  - Controller req rises in cycle N+1 (one-cycle grant latency).
- Zero-length burst (len==0) at grant: no controller req is issued. Pulse the client finish in cycle N+1, then go to RELEASE.
- GNT_WR / GNT_RD:
  - Controller req stays high until the first wr_burst_data_req (write) or rd_burst_data_valid (read), then drops.
  - Client req is ignored after grant; addr/len stay frozen.
- Routing (combinational, gated by grant):
  - c_wr_burst_data_req = wr_burst_data_req & grant_wr; wr_burst_data = c_wr_burst_data.
  - c_rd_burst_data_valid = rd_burst_data_valid & grant_rd; c_rd_burst_data = rd_burst_data.
  - Finish is forwarded as finish & grant.
  - Strobes from the controller on the non-granted port are dropped.
- Finish: on the controller finish for the granted port, clear grant and the watchdog and go to RELEASE. Finish is not forwarded from a port that has no grant.
- RELEASE: exactly one idle cycle, then IDLE. This gives a guaranteed gap between bursts, so back-to-back bursts from the same client have a minimum period of burst + 3 cycles.
- Watchdog:
  - Counts every cycle in GNT_x.
  - At TIMEOUT_CYCLES with no finish: drop controller req, pulse client finish and arb_timeout, set arb_err, go to RELEASE.
  - A late controller finish that arrives afterwards is ignored.
- Simultaneous finish and timeout in the same cycle: finish wins; no arb_timeout pulse, arb_err unchanged.
- Fairness: with both clients requesting continuously, grants strictly alternate WR, RD, WR, and so on.
- rst_n asserted mid-burst: immediate return to reset values. Clients must re-request. The controller must itself be reset by the same rst_n.
- Widths: watchdog counter is clog2(TIMEOUT_CYCLES+1) bits and saturates. No address arithmetic is done in this block.

Decomposition:
- Shared package sdram_arb_pkg holds:
  - state encoding (IDLE, GNT_WR, GNT_RD, RELEASE)
  - client index constants WR=0, RD=1
  - default TIMEOUT_CYCLES
- One sub-module, burst_watchdog: a counter with clear/enable inputs and an expire output, reusable by the frame sequencers.

Test Plan:
- Write req only, len=128, addr=0x000100 -> wr_burst_req rises 1 cycle after req; addr/len match; 128 c_wr_burst_data_req strobes; one c_wr_burst_finish; grant_wr low in RELEASE.
- Write and read requested in the same cycle after reset -> WR granted first, then RD after finish+RELEASE; continuous requests alternate WR,RD,WR,RD over 4 bursts.
- During a WR grant, inject rd_burst_data_valid/rd_burst_finish -> c_rd_* stay 0; no state change.
- Read req, len=0 -> no rd_burst_req; c_rd_burst_finish pulses 1 cycle after grant; next grant proceeds normally.
- Read granted, controller never finishes, TIMEOUT_CYCLES=16 -> at cycle 16 rd_burst_req is 0, arb_timeout pulses once, arb_err stays 1, c_rd_burst_finish pulses; a later rd_burst_finish is ignored.
- rst_n pulled low mid-burst (word 40 of 128) -> all outputs return to reset values asynchronously; the first post-reset tie grants WR.
